// File: rtl/nibble_accumulator.sv
// ---------------------------------------------------------------------------
// nibble_accumulator
//
// Purpose:
//   Sums a window of NUM_SAMPLES 4-bit samples into a (CARRY_W+4)-bit total.
//   The low nibble comes from an external 4-bit adder that has no carry-in.
//   This block drives the adder's operands and captures its sum. The adder's
//   carry-out increments a carry counter, which supplies the upper bits of the
//   total. Each finished window is presented on a valid/ready output port.
//
// Parameters:
//   NUM_SAMPLES  samples per window (2..255)
//   CARRY_W      carry-counter width; out_data is CARRY_W+4 bits
//
// Optional feature:
//   NIBBLE_ACCUMULATOR_FLUSH_EN  adds input 'flush', which ends a non-empty
//                                window early with its partial total.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data valid
//   in_ready   out  sample accepted this cycle when in_valid is also high
//   in_data    in   4-bit sample
//   add_a      out  adder operand a (running accumulator)
//   add_b      out  adder operand b (in_data)
//   add_sum    in   adder sum
//   add_cout   in   adder carry-out
//   out_valid  out  window result valid
//   out_ready  in   consumer accepts result
//   out_data   out  {carry_cnt, acc} of the finished window
//   out_ovf    out  carry counter wrapped during the window
//   flush      in   (feature only) end the current window early
// ---------------------------------------------------------------------------
module nibble_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int CARRY_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  input  logic [3:0]         add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CARRY_W+3:0] out_data,
  output logic               out_ovf
`ifdef NIBBLE_ACCUMULATOR_FLUSH_EN
  ,
  input  logic               flush
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

  typedef enum logic {
    S_ACCUM,
    S_OUT
  } state_t;

  state_t               state_q;
  logic [3:0]           acc_q;
  logic [CARRY_W-1:0]   carry_q;
  logic [7:0]           cnt_q;
  logic                 ovf_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [CARRY_W+3:0]   out_data_q;
  logic                 out_ovf_q;

  logic                 accept;
  logic                 end_win;
  logic [3:0]           acc_d;
  logic [CARRY_W-1:0]   carry_d;
  logic                 ovf_d;

  // The adder sits outside; its operands are pure wires from our state.
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Accumulator values after the current cycle. If a sample is accepted this
  // cycle, they include it. These values feed both the state update and the
  // captured result, so the last sample's sum lands in out_data with no
  // extra cycle.
  always_comb begin
    accept  = in_valid & in_ready_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      acc_d   = add_sum;
      carry_d = carry_q + CARRY_W'(add_cout);
      // The counter wraps when it is all-ones and another carry arrives.
      ovf_d   = ovf_q | ((&carry_q) & add_cout);
    end
    end_win = accept && (cnt_q == LAST_IDX);
`ifdef NIBBLE_ACCUMULATOR_FLUSH_EN
    // Flush only ends a window that holds at least one sample, counting a
    // sample accepted in the same cycle.
    if (flush && (accept || (cnt_q != 8'd0))) begin
      end_win = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCUM;
      acc_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_q + 8'd1;
          end
          if (end_win) begin
            state_q     <= S_OUT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= {carry_d, acc_d};
            out_ovf_q   <= ovf_d;
          end
        end
        S_OUT: begin
          // The result holds until the consumer takes it. Input is only
          // re-enabled on the following cycle.
          if (out_ready) begin
            state_q     <= S_ACCUM;
            acc_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_ACCUM;
        end
      endcase
    end
  end

endmodule
